// File: rtl/rs_adder_share_sched.sv
// rs_adder_share_sched: time-shares one SEG-bit adder slice among NREQ
// requesters doing WIDTH-bit add/subtract, least-significant segment first.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not wait for ready, and the payload travelling with
// valid is only required to be stable in the cycle it transfers.
module rs_adder_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    localparam int NSEG = WIDTH / SEG,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    C,
    input  logic                    R,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_co,
    output logic                    rsp_ovf,
    output logic [1:0]              dbg_state_o
);

    localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEGW-1:0] SEG_LAST = SEGW'(NSEG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [SEGW-1:0]   seg_q, seg_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              co_q, co_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;

    logic [SEG-1:0]    a_lo;
    logic [SEG-1:0]    b_x;
    logic [SEG-1:0]    s_seg;
    logic              c_out;
    logic              c_msb_in;

    // Requester index base+off, wrapped into 0..NREQ-1 (off is 0..NREQ).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin search from rr_q upward; first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[wrap_idx(rr_q, k)]) begin
                gnt_any                = 1'b1;
                gnt_idx                = wrap_idx(rr_q, k);
                gnt[wrap_idx(rr_q, k)] = 1'b1;
            end
        end
    end

    // Grants are only offered while idle; reset forces them off immediately.
    assign req_ready = (state_q == S_IDLE && R) ? gnt : '0;

    // Shared slice: current low segment of the shifted operands plus carry.
    always_comb begin
        a_lo             = a_q[SEG-1:0];
        b_x              = sub_q ? ~b_q[SEG-1:0] : b_q[SEG-1:0];
        {c_out, s_seg}   = {1'b0, a_lo} + {1'b0, b_x} + {{SEG{1'b0}}, carry_q};
        // Carry into the top bit is recovered from the top bit's sum parity.
        c_msb_in         = a_lo[SEG-1] ^ b_x[SEG-1] ^ s_seg[SEG-1];
    end

    // Next-state and datapath updates for IDLE / RUN / RESP.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        seg_d   = seg_q;
        sum_d   = sum_q;
        id_d    = id_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    a_d     = req_a[gnt_idx*WIDTH +: WIDTH];
                    b_d     = req_b[gnt_idx*WIDTH +: WIDTH];
                    sub_d   = req_sub[gnt_idx];
                    carry_d = req_sub[gnt_idx];
                    seg_d   = '0;
                    id_d    = gnt_idx;
                    rr_d    = wrap_idx(gnt_idx, 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Operands shift down so the slice always sees segment 0;
                // results shift in from the top and land aligned after NSEG steps.
                a_d     = a_q >> SEG;
                b_d     = b_q >> SEG;
                sum_d   = {s_seg, sum_q[WIDTH-1:SEG]};
                carry_d = c_out;
                seg_d   = seg_q + SEGW'(1);
                if (seg_q == SEG_LAST) begin
                    co_d    = c_out;
                    ovf_d   = c_msb_in ^ c_out;
                    valid_d = 1'b1;
                    seg_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            seg_q   <= '0;
            sum_q   <= '0;
            id_q    <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            seg_q   <= seg_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign rsp_valid   = valid_q;
    assign rsp_id      = id_q;
    assign rsp_sum     = sum_q;
    assign rsp_co      = co_q;
    assign rsp_ovf     = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rs_adder_share_sched.sv
// Directed bench for rs_adder_share_sched with hand-computed expectations.
module tb_rs_adder_share_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;
    localparam int IDW   = 2;
    localparam int WAIT_MAX = 20;

    logic                  C;
    logic                  R;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_co;
    logic                  rsp_ovf;
    logic [1:0]            dbg_state_o;

    int n_checks = 0;
    int n_err    = 0;

    rs_adder_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SEG(SEG)) dut (
        .C           (C),
        .R           (R),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sub     (req_sub),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_sum     (rsp_sum),
        .rsp_co      (rsp_co),
        .rsp_ovf     (rsp_ovf),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Issue one operation from requester id and check its response.
    task automatic do_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [WIDTH-1:0] e_sum,
                         input logic e_co, input logic e_ovf);
        int w;
        int lat;
        logic [NREQ-1:0] e_gnt;
        e_gnt = '0;
        e_gnt[id] = 1'b1;
        req_valid = '0;
        req_sub   = '0;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_sub[id]   = sub;
        req_valid[id] = 1'b1;
        #1;
        w = 0;
        while (req_ready[id] !== 1'b1 && w < WAIT_MAX) begin
            tick();
            w++;
        end
        chk("op_grant", req_ready, e_gnt);
        tick();
        req_valid = '0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < WAIT_MAX) begin
            tick();
            lat++;
        end
        chk("op_latency", lat, NSEG);
        chk("op_id", rsp_id, id);
        chk("op_sum", rsp_sum, e_sum);
        chk("op_co", rsp_co, e_co);
        chk("op_ovf", rsp_ovf, e_ovf);
        if (rsp_ready) begin
            tick();
            chk("op_rsp_clear", rsp_valid, 0);
        end
    endtask

    initial begin
        int w;
        int eid;
        logic [NREQ-1:0] e_gnt;

        R         = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests pending to see grants are suppressed
        repeat (3) @(posedge C);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_co", rsp_co, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_state", dbg_state_o, 0);
        req_valid = '0;
        R = 1'b1;
        tick();

        // Directed arithmetic vectors
        do_op(2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op(0, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        do_op(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: result held for 10 cycles while requester 3 waits
        rsp_ready = 1'b0;
        do_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        req_valid = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_sum", rsp_sum, 32'h2345_6789);
            chk("bp_id", rsp_id, 1);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_grant", req_ready, 4'b1000);
        req_valid = '0;
        tick();

        // Reset in the second RUN cycle aborts the operation
        req_a[2*WIDTH +: WIDTH] = 32'h0F0F_0F0F;
        req_b[2*WIDTH +: WIDTH] = 32'h0101_0101;
        req_sub   = '0;
        req_valid = 4'b0100;
        #1;
        w = 0;
        while (req_ready[2] !== 1'b1 && w < WAIT_MAX) begin
            tick();
            w++;
        end
        chk("abort_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        chk("abort_pre_id", rsp_id, 2);
        chk("abort_pre_state", dbg_state_o, 1);
        R = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_rsp_sum", rsp_sum, 0);
        chk("abort_state", dbg_state_o, 0);
        req_valid = 4'b1000;
        #1;
        chk("abort_req_ready", req_ready, 0);
        tick();
        tick();
        chk("abort_no_rsp", rsp_valid, 0);
        R = 1'b1;
        do_op(3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

        // Round-robin with every requester valid: order 0,1,2,3,0,1
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 32'h100 * i + 32'h1;
            req_b[i*WIDTH +: WIDTH] = 32'h10;
        end
        req_sub   = '0;
        req_valid = '1;
        #1;
        for (int n = 0; n < 6; n++) begin
            eid = n % NREQ;
            e_gnt = '0;
            e_gnt[eid] = 1'b1;
            w = 0;
            while (req_ready === '0 && w < WAIT_MAX) begin
                tick();
                w++;
            end
            chk("rr_grant", req_ready, e_gnt);
            tick();
            w = 0;
            while (rsp_valid !== 1'b1 && w < WAIT_MAX) begin
                tick();
                w++;
            end
            chk("rr_id", rsp_id, eid);
            chk("rr_sum", rsp_sum, 32'h100 * eid + 32'h11);
            tick();
        end
        req_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
